sr_ex_stage: RTL and testbench
==============================

SR_EX_STAGE -- requirements
Module: sr_ex_stage

Interface
REQ-001 Parameter: FWD_EN, default 1, enables operand forwarding; 0 selects captured register values only.
REQ-002 Clock and reset: one clock, reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 in_valid / in_ready  input / output  1  decode-side handshake.
REQ-006 in_rs1_val, in_rs2_val, in_imm  input  32  operands and immediate.
REQ-007 in_rs1_addr, in_rs2_addr, in_rd_addr  input  5  source and destination register numbers.
REQ-008 in_use_imm, in_rd_we  input  1  srcB-from-immediate select; register-write enable.
REQ-009 in_oper  input  3  ALU operation code, passed unchanged.
REQ-010 flush  input  1  kills the EX-slot instruction.
REQ-011 alu_srcA, alu_srcB  output  32  to ALU; alu_oper output 3.
REQ-012 alu_result  input  32  from ALU; alu_zero input 1.
REQ-013 wb_we  input  1  writeback write enable; wb_addr input 5; wb_data input 32.
REQ-014 out_valid / out_ready  output / input  1  writeback-side handshake.
REQ-015 out_rd_addr output 5; out_rd_we output 1; out_result output 32; out_zero output 1.

Function
REQ-016 Two register slots: EX slot (captures accepted instruction) and RES slot (captures ALU outputs); each has a valid bit.
REQ-017 res_free = !out_valid || out_ready; ex_adv = ex_valid && res_free.
REQ-018 in_ready = (!ex_valid || res_free) && !flush, combinational.
REQ-019 in_valid && in_ready at edge N: EX slot loads all in_* fields, ex_valid=1.
REQ-020 ex_adv at edge N: RES slot loads alu_result, alu_zero, rd_addr, rd_we; out_valid=1.
REQ-021 out_valid && out_ready && !ex_adv: out_valid=0 next cycle.
REQ-022 ex_valid && !ex_adv && no new accept: EX slot holds; ex_valid drops to 0 only when it advances without a new accept.
REQ-023 Latency: acceptance at edge N -> out_valid high after edge N+1 with no stall; sustains one instruction per cycle.
REQ-024 RES slot and out_* hold stable while out_valid && !out_ready.
REQ-025 alu_oper = EX oper; alu_srcB = in_use_imm-captured ? EX imm : fwd rs2; alu_srcA = fwd rs1.
REQ-026 Forward rsX priority (FWD_EN=1): RES slot if out_valid && out_rd_we && out_rd_addr==rsX && rsX!=0; else wb port if wb_we && wb_addr==rsX && rsX!=0; else captured value.
REQ-027 Register x0 never forwarded; x0 source always yields captured value.
REQ-028 flush at edge: ex_valid=0, no accept that cycle, RES slot unaffected; flush with ex_adv in same cycle: EX instruction is killed, not moved to RES.
REQ-029 Simultaneous advance and accept: RES takes old EX result, EX takes new instruction, same edge.
REQ-030 out_rd_we = 0 whenever out_valid = 0.

Reset
REQ-031 rst high: ex_valid=0, out_valid=0, out_result=0, out_zero=0, out_rd_addr=0, out_rd_we=0, EX fields=0, asynchronously.
REQ-032 rst asserted mid-operation discards both slots; first accept possible on first edge after rst low.

Verification
REQ-033 ADD rs1=5,rs2=7, out_ready=1, accept edge 0 -> out_valid=1 after edge 1, out_result=12, out_zero=0.
REQ-034 Back-to-back: I1 ADD x3=x1(10)+x2(20); I2 ADD x4=x3(stale 0)+x3 -> I2 out_result=60 via RES forwarding.
REQ-035 out_ready=0 for 3 cycles with 2 instructions in flight -> in_ready=0, out_* stable, both results delivered in order once out_ready=1.
REQ-036 rd=x0 with rd_we=1, next instruction reads x0 (captured 0) -> srcA=0, no forwarding.
REQ-037 flush while EX holds SUB 9-9 -> no output produced, out_zero unchanged; later instructions unaffected.
REQ-038 rst asserted with out_valid=1 -> out_valid=0 and out_result=0 immediately, without a clock edge.

Source files
------------

// File: rtl/sr_ex_stage.sv
// Execute stage: an EX slot holding the accepted instruction, feeding an
// external ALU, and a RES slot capturing the ALU outputs for writeback.
// Operands for the ALU are forwarded from the RES slot or the writeback port.
module sr_ex_stage #(
  parameter int unsigned FWD_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  // decode side
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_rs1_val,
  input  logic [31:0] in_rs2_val,
  input  logic [31:0] in_imm,
  input  logic [4:0]  in_rs1_addr,
  input  logic [4:0]  in_rs2_addr,
  input  logic [4:0]  in_rd_addr,
  input  logic        in_use_imm,
  input  logic        in_rd_we,
  input  logic [2:0]  in_oper,
  input  logic        flush,
  // ALU
  output logic [31:0] alu_srcA,
  output logic [31:0] alu_srcB,
  output logic [2:0]  alu_oper,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  // writeback port (forwarding source)
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  // writeback side
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_rd_addr,
  output logic        out_rd_we,
  output logic [31:0] out_result,
  output logic        out_zero
);

  // EX slot
  logic        ex_valid_q, ex_valid_d;
  logic [31:0] ex_rs1_val_q, ex_rs2_val_q, ex_imm_q;
  logic [4:0]  ex_rs1_addr_q, ex_rs2_addr_q, ex_rd_addr_q;
  logic        ex_use_imm_q, ex_rd_we_q;
  logic [2:0]  ex_oper_q;

  // RES slot
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_result_q;
  logic        out_zero_q;
  logic [4:0]  out_rd_addr_q;
  logic        out_rd_we_q;

  logic res_free, ex_adv, accept, res_load;
  logic [31:0] fwd_rs1, fwd_rs2;

  assign res_free = !out_valid_q || out_ready;
  assign ex_adv   = ex_valid_q && res_free;
  assign in_ready = (!ex_valid_q || res_free) && !flush;
  assign accept   = in_valid && in_ready;
  // A flushed instruction never reaches RES, even if it could advance.
  assign res_load = ex_adv && !flush;

  // Operand source select: RES slot beats writeback port; x0 is never forwarded.
  function automatic logic [31:0] fwd_sel(
    input logic [4:0]  rs,
    input logic [31:0] cap,
    input logic        res_hit_en,
    input logic [4:0]  res_addr,
    input logic [31:0] res_data,
    input logic        wb_en,
    input logic [4:0]  wb_a,
    input logic [31:0] wb_d
  );
    logic [31:0] r;
    r = cap;
    if (FWD_EN != 0 && rs != 5'd0) begin
      if (res_hit_en && res_addr == rs) r = res_data;
      else if (wb_en && wb_a == rs)     r = wb_d;
    end
    return r;
  endfunction

  // Forwarded operand values for the instruction sitting in EX.
  always_comb begin
    fwd_rs1 = fwd_sel(ex_rs1_addr_q, ex_rs1_val_q, out_rd_we, out_rd_addr_q,
                      out_result_q, wb_we, wb_addr, wb_data);
    fwd_rs2 = fwd_sel(ex_rs2_addr_q, ex_rs2_val_q, out_rd_we, out_rd_addr_q,
                      out_result_q, wb_we, wb_addr, wb_data);
  end

  assign alu_srcA = fwd_rs1;
  assign alu_srcB = ex_use_imm_q ? ex_imm_q : fwd_rs2;
  assign alu_oper = ex_oper_q;

  // Slot occupancy next-state.
  always_comb begin
    ex_valid_d  = ex_valid_q;
    out_valid_d = out_valid_q;
    if (flush)        ex_valid_d = 1'b0;
    else if (accept)  ex_valid_d = 1'b1;
    else if (ex_adv)  ex_valid_d = 1'b0;
    if (res_load)       out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
  end

  // EX slot register: loads on accept, otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q    <= 1'b0;
      ex_rs1_val_q  <= '0;
      ex_rs2_val_q  <= '0;
      ex_imm_q      <= '0;
      ex_rs1_addr_q <= '0;
      ex_rs2_addr_q <= '0;
      ex_rd_addr_q  <= '0;
      ex_use_imm_q  <= 1'b0;
      ex_rd_we_q    <= 1'b0;
      ex_oper_q     <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      if (accept) begin
        ex_rs1_val_q  <= in_rs1_val;
        ex_rs2_val_q  <= in_rs2_val;
        ex_imm_q      <= in_imm;
        ex_rs1_addr_q <= in_rs1_addr;
        ex_rs2_addr_q <= in_rs2_addr;
        ex_rd_addr_q  <= in_rd_addr;
        ex_use_imm_q  <= in_use_imm;
        ex_rd_we_q    <= in_rd_we;
        ex_oper_q     <= in_oper;
      end
    end
  end

  // RES slot register: captures ALU outputs when EX advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_zero_q    <= 1'b0;
      out_rd_addr_q <= '0;
      out_rd_we_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (res_load) begin
        out_result_q  <= alu_result;
        out_zero_q    <= alu_zero;
        out_rd_addr_q <= ex_rd_addr_q;
        out_rd_we_q   <= ex_rd_we_q;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_zero    = out_zero_q;
  assign out_rd_addr = out_rd_addr_q;
  assign out_rd_we   = out_valid_q && out_rd_we_q;

endmodule

// File: tb/tb_sr_ex_stage.sv
// Directed bench for sr_ex_stage with a small behavioural ALU.
// Inputs change and outputs are sampled on the falling edge.
module tb_sr_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_rs1_val, in_rs2_val, in_imm;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic        in_use_imm, in_rd_we;
  logic [2:0]  in_oper;
  logic        flush;
  logic [31:0] alu_srcA, alu_srcB;
  logic [2:0]  alu_oper;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [4:0]  out_rd_addr;
  logic        out_rd_we;
  logic [31:0] out_result;
  logic        out_zero;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1;

  sr_ex_stage #(.FWD_EN(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_use_imm(in_use_imm), .in_rd_we(in_rd_we), .in_oper(in_oper),
    .flush(flush),
    .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_oper(alu_oper),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we),
    .out_result(out_result), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  // Reference ALU: 0 add, 1 sub, otherwise and.
  always_comb begin
    case (alu_oper)
      OP_ADD:  alu_result = alu_srcA + alu_srcB;
      OP_SUB:  alu_result = alu_srcA - alu_srcB;
      default: alu_result = alu_srcA & alu_srcB;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic set_instr(input logic [4:0] a1, input logic [31:0] v1,
                           input logic [4:0] a2, input logic [31:0] v2,
                           input logic [31:0] imm, input logic use_imm,
                           input logic [4:0] rd, input logic we, input logic [2:0] op);
    in_valid = 1'b1;
    in_rs1_addr = a1; in_rs1_val = v1;
    in_rs2_addr = a2; in_rs2_val = v2;
    in_imm = imm; in_use_imm = use_imm;
    in_rd_addr = rd; in_rd_we = we; in_oper = op;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_result !== 32'd0 || out_zero !== 1'b0 || out_rd_addr !== 5'd0 || out_rd_we !== 1'b0) begin
      n_err++; $display("FAIL reset_res: got res=%0d z=%b rd=%0d we=%b want all 0", out_result, out_zero, out_rd_addr, out_rd_we); end
    n_cmp++; if (alu_srcA !== 32'd0 || alu_oper !== 3'd0) begin n_err++; $display("FAIL reset_ex: got srcA=%0d oper=%0d want 0", alu_srcA, alu_oper); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    set_instr(5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 1'b0, 5'd3, 1'b1, OP_ADD);
    cyc();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL add_lat0: got out_valid=%b want 0", out_valid); end
    n_cmp++; if (alu_srcA !== 32'd5 || alu_srcB !== 32'd7) begin n_err++; $display("FAIL add_srcs: got %0d,%0d want 5,7", alu_srcA, alu_srcB); end
    cyc();
    n_cmp++; if (out_valid !== 1'b1 || out_result !== 32'd12 || out_zero !== 1'b0 || out_rd_addr !== 5'd3) begin
      n_err++; $display("FAIL add_out: got v=%b r=%0d z=%b rd=%0d want 1,12,0,3", out_valid, out_result, out_zero, out_rd_addr); end
    cyc();
    n_cmp++; if (out_valid !== 1'b0 || out_rd_we !== 1'b0) begin n_err++; $display("FAIL add_drain: got v=%b we=%b want 0,0", out_valid, out_rd_we); end
  endtask

  // RES forwarding, and RES beating a simultaneous writeback hit.
  task automatic test_back_to_back();
    set_instr(5'd1, 32'd10, 5'd2, 32'd20, 32'd0, 1'b0, 5'd3, 1'b1, OP_ADD);
    cyc();
    set_instr(5'd3, 32'd0, 5'd3, 32'd0, 32'd0, 1'b0, 5'd4, 1'b1, OP_ADD);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
    cyc();
    in_valid = 1'b0;
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'd999;
    #1;
    n_cmp++; if (out_result !== 32'd30 || alu_srcA !== 32'd30 || alu_srcB !== 32'd30) begin
      n_err++; $display("FAIL b2b_fwd: got res=%0d a=%0d b=%0d want 30,30,30", out_result, alu_srcA, alu_srcB); end
    cyc();
    wb_we = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_result !== 32'd60 || out_rd_addr !== 5'd4) begin
      n_err++; $display("FAIL b2b_i2: got v=%b r=%0d rd=%0d want 1,60,4", out_valid, out_result, out_rd_addr); end
    cyc();
  endtask

  task automatic test_wb_fwd();
    wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'd55;
    set_instr(5'd1, 32'd3, 5'd2, 32'd4, 32'd0, 1'b0, 5'd6, 1'b1, OP_ADD);
    cyc();
    in_valid = 1'b0;
    cyc();
    wb_we = 1'b0;
    n_cmp++; if (out_result !== 32'd59) begin n_err++; $display("FAIL wb_fwd: got %0d want 59", out_result); end
    cyc();
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    set_instr(5'd6, 32'd1, 5'd7, 32'd2, 32'd0, 1'b0, 5'd5, 1'b1, OP_ADD);
    cyc();
    set_instr(5'd8, 32'd100, 5'd9, 32'd3, 32'd0, 1'b0, 5'd10, 1'b1, OP_SUB);
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_result !== 32'd3 || out_rd_addr !== 5'd5 || in_ready !== 1'b0) begin
        n_err++; $display("FAIL stall_hold%0d: got v=%b r=%0d rd=%0d rdy=%b want 1,3,5,0", i, out_valid, out_result, out_rd_addr, in_ready); end
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    n_cmp++; if (out_valid !== 1'b1 || out_result !== 32'd97 || out_rd_addr !== 5'd10) begin
      n_err++; $display("FAIL stall_second: got v=%b r=%0d rd=%0d want 1,97,10", out_valid, out_result, out_rd_addr); end
    cyc();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_x0();
    set_instr(5'd1, 32'd4, 5'd2, 32'd5, 32'd0, 1'b0, 5'd0, 1'b1, OP_ADD);
    cyc();
    set_instr(5'd0, 32'd0, 5'd0, 32'd0, 32'd7, 1'b1, 5'd12, 1'b1, OP_ADD);
    cyc();
    in_valid = 1'b0;
    n_cmp++; if (out_result !== 32'd9 || alu_srcA !== 32'd0 || alu_srcB !== 32'd7) begin
      n_err++; $display("FAIL x0_nofwd: got res=%0d a=%0d b=%0d want 9,0,7", out_result, alu_srcA, alu_srcB); end
    cyc();
    n_cmp++; if (out_result !== 32'd7 || out_zero !== 1'b0) begin n_err++; $display("FAIL x0_out: got %0d z=%b want 7,0", out_result, out_zero); end
    cyc();
  endtask

  task automatic test_flush();
    set_instr(5'd13, 32'd9, 5'd14, 32'd9, 32'd0, 1'b0, 5'd11, 1'b1, OP_SUB);
    cyc();
    in_valid = 1'b0;
    flush = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %b want 0", in_ready); end
    cyc();
    flush = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || out_zero !== 1'b0) begin n_err++; $display("FAIL flush_kill: got v=%b z=%b want 0,0", out_valid, out_zero); end
    cyc();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_late: got %b want 0", out_valid); end
    set_instr(5'd13, 32'd2, 5'd14, 32'd3, 32'd0, 1'b0, 5'd15, 1'b1, OP_ADD);
    cyc();
    in_valid = 1'b0;
    cyc();
    n_cmp++; if (out_valid !== 1'b1 || out_result !== 32'd5) begin n_err++; $display("FAIL flush_after: got v=%b r=%0d want 1,5", out_valid, out_result); end
    cyc();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    set_instr(5'd1, 32'd40, 5'd2, 32'd2, 32'd0, 1'b0, 5'd16, 1'b1, OP_ADD);
    cyc();
    in_valid = 1'b0;
    cyc();
    n_cmp++; if (out_valid !== 1'b1 || out_result !== 32'd42) begin n_err++; $display("FAIL arst_pre: got v=%b r=%0d want 1,42", out_valid, out_result); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_result !== 32'd0 || out_rd_we !== 1'b0) begin
      n_err++; $display("FAIL arst_now: got v=%b r=%0d we=%b want 0,0,0", out_valid, out_result, out_rd_we); end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    set_instr(5'd1, 32'd1, 5'd2, 32'd1, 32'd0, 1'b0, 5'd17, 1'b1, OP_ADD);
    cyc();
    in_valid = 1'b0;
    cyc();
    n_cmp++; if (out_valid !== 1'b1 || out_result !== 32'd2 || out_rd_addr !== 5'd17) begin
      n_err++; $display("FAIL arst_after: got v=%b r=%0d rd=%0d want 1,2,17", out_valid, out_result, out_rd_addr); end
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_rs1_val = '0; in_rs2_val = '0; in_imm = '0;
    in_rs1_addr = '0; in_rs2_addr = '0; in_rd_addr = '0;
    in_use_imm = 1'b0; in_rd_we = 1'b0; in_oper = '0;
    flush = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    out_ready = 1'b1;
    test_reset();
    test_add();
    test_back_to_back();
    test_wb_fwd();
    test_stall();
    test_x0();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
